// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared constants and types for the hazard/forwarding controller: select
// encodings, register address width and the hazard FSM state encoding.
package hazard_forward_ctrl_pkg;

    localparam int REG_ADDR_LEN = 5;
    localparam int FORW_SEL_LEN = 2;

    localparam logic [FORW_SEL_LEN-1:0] FORW_SEL_REG = 2'd0;
    localparam logic [FORW_SEL_LEN-1:0] FORW_SEL_MEM = 2'd1;
    localparam logic [FORW_SEL_LEN-1:0] FORW_SEL_WB  = 2'd2;

    typedef enum logic {
        HZ_RUN   = 1'b0,
        HZ_STALL = 1'b1
    } hz_state_e;

    // MEM outranks WB because it carries the younger value of the register.
    function automatic logic [FORW_SEL_LEN-1:0] pick_sel(input logic mem_hit, input logic wb_hit);
        if (mem_hit) begin
            return FORW_SEL_MEM;
        end
        if (wb_hit) begin
            return FORW_SEL_WB;
        end
        return FORW_SEL_REG;
    endfunction

endpackage

// File: rtl/hazard_forward_ctrl_if.sv
// Bundle between the decode/execute pipeline (master) and the hazard and
// forwarding controller (slave), plus the controller's FSM debug view.
interface hazard_forward_ctrl_if #(
    parameter int REG_ADDR_W = hazard_forward_ctrl_pkg::REG_ADDR_LEN
) ();
    import hazard_forward_ctrl_pkg::*;

    // Handshake: the ID fields are meaningful only in a cycle with id_valid=1.
    // There is no ready; stall=1 is the back-pressure, meaning the ID
    // instruction was not accepted and must be presented again next cycle.
    logic                    id_valid;
    logic [REG_ADDR_W-1:0]   id_src1;
    logic [REG_ADDR_W-1:0]   id_src2;
    logic                    id_uses_src2;
    logic                    id_is_store;
    logic [REG_ADDR_W-1:0]   id_dest;
    logic                    id_wb_en;
    logic                    id_mem_read;
    logic                    branch_taken;
    logic                    mem_freeze;
    logic [FORW_SEL_LEN-1:0] val1_sel;
    logic [FORW_SEL_LEN-1:0] val2_sel;
    logic [FORW_SEL_LEN-1:0] ST_val_sel;
    logic                    stall;
    logic                    bubble;
    hz_state_e               hz_state;

    modport master (
        output id_valid, id_src1, id_src2, id_uses_src2, id_is_store,
               id_dest, id_wb_en, id_mem_read, branch_taken, mem_freeze,
        input  val1_sel, val2_sel, ST_val_sel, stall, bubble, hz_state
    );

    modport slave (
        input  id_valid, id_src1, id_src2, id_uses_src2, id_is_store,
               id_dest, id_wb_en, id_mem_read, branch_taken, mem_freeze,
        output val1_sel, val2_sel, ST_val_sel, stall, bubble, hz_state
    );

endinterface

// File: rtl/hazard_forward_ctrl_fwd_src_match.sv
// Resolves one EXE source register against the MEM and WB shadow slots and
// returns the operand select for it.
module fwd_src_match
    import hazard_forward_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_LEN
) (
    input  logic [REG_ADDR_W-1:0]   src,
    input  logic                    mem_valid,
    input  logic                    mem_wb_en,
    input  logic                    mem_mem_read,
    input  logic [REG_ADDR_W-1:0]   mem_dest,
    input  logic                    wb_valid,
    input  logic                    wb_wb_en,
    input  logic [REG_ADDR_W-1:0]   wb_dest,
    output logic [FORW_SEL_LEN-1:0] sel
);

    logic src_nz;
    logic mem_hit;
    logic wb_hit;

    assign src_nz  = (src != '0);
    // A load in MEM has no ALU result worth forwarding; the stall keeps it away.
    assign mem_hit = mem_valid & mem_wb_en & ~mem_mem_read & (mem_dest == src) & src_nz;
    assign wb_hit  = wb_valid & wb_wb_en & (wb_dest == src) & src_nz;
    assign sel     = pick_sel(mem_hit, wb_hit);

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard and forwarding controller: shadow EXE/MEM/WB slots, Moore operand
// selects and a RUN/STALL hazard FSM. Forwarding is enabled by FORWARDING_EN.
module hazard_forward_ctrl
    import hazard_forward_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_LEN
) (
    input  logic                   clk,
    input  logic                   rst,
    hazard_forward_ctrl_if.slave   bus
);

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] src1;
        logic [REG_ADDR_W-1:0] src2;
        logic                  uses_src2;
        logic                  is_store;
        logic [REG_ADDR_W-1:0] dest;
        logic                  wb_en;
        logic                  mem_read;
    } exe_slot_t;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] dest;
        logic                  wb_en;
        logic                  mem_read;
    } mem_slot_t;

    // Nothing downstream of WB asks whether it was a load.
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] dest;
        logic                  wb_en;
    } wb_slot_t;

    exe_slot_t exe_q, exe_d;
    mem_slot_t mem_q, mem_d;
    wb_slot_t  wb_q, wb_d;
    hz_state_e state_q, state_d;

    logic hazard, stall_c, bubble_c;
    logic src2_act, ex_s1, ex_s2;
    logic [FORW_SEL_LEN-1:0] sel1, sel2, sel3;

    function automatic logic hits(input logic v, input logic wb, input logic [REG_ADDR_W-1:0] d,
                                  input logic [REG_ADDR_W-1:0] x);
        return v & wb & (d == x) & (x != '0);
    endfunction

    assign src2_act = bus.id_uses_src2 | bus.id_is_store;
    assign ex_s1    = hits(exe_q.valid, exe_q.wb_en, exe_q.dest, bus.id_src1);
    assign ex_s2    = hits(exe_q.valid, exe_q.wb_en, exe_q.dest, bus.id_src2);

`ifdef FORWARDING_EN
    localparam logic FWD_ON = 1'b1;
    assign hazard = bus.id_valid & exe_q.mem_read & (ex_s1 | (src2_act & ex_s2));
`else
    localparam logic FWD_ON = 1'b0;
    logic mem_s1, mem_s2;
    assign mem_s1 = hits(mem_q.valid, mem_q.wb_en, mem_q.dest, bus.id_src1);
    assign mem_s2 = hits(mem_q.valid, mem_q.wb_en, mem_q.dest, bus.id_src2);
    assign hazard = bus.id_valid & (ex_s1 | mem_s1 | (src2_act & (ex_s2 | mem_s2)));
`endif

    always_comb begin
        state_d  = state_q;
        stall_c  = 1'b0;
        bubble_c = 1'b0;
        case (state_q)
            HZ_RUN:   if (hazard)  state_d = HZ_STALL;
            HZ_STALL: if (!hazard) state_d = HZ_RUN;
            default:  state_d = HZ_RUN;
        endcase
        if (hazard) begin
            stall_c  = 1'b1;
            bubble_c = 1'b1;
        end
        // A taken branch squashes ID, so there is nothing left to hold.
        if (bus.branch_taken) begin
            stall_c  = 1'b0;
            bubble_c = 1'b1;
            state_d  = HZ_RUN;
        end
        if (bus.mem_freeze) begin
            state_d = state_q;
        end
    end

    always_comb begin
        exe_d = exe_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        if (!bus.mem_freeze) begin
            wb_d  = '{valid: mem_q.valid, dest: mem_q.dest, wb_en: mem_q.wb_en};
            mem_d = '{valid: exe_q.valid, dest: exe_q.dest, wb_en: exe_q.wb_en,
                      mem_read: exe_q.mem_read};
            exe_d = '0;
            if (bus.id_valid && !stall_c && !bus.branch_taken) begin
                exe_d.valid     = 1'b1;
                exe_d.src1      = bus.id_src1;
                exe_d.src2      = bus.id_src2;
                exe_d.uses_src2 = bus.id_uses_src2;
                exe_d.is_store  = bus.id_is_store;
                exe_d.dest      = bus.id_dest;
                exe_d.wb_en     = bus.id_wb_en;
                exe_d.mem_read  = bus.id_mem_read;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exe_q   <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            state_q <= HZ_RUN;
        end else begin
            exe_q   <= exe_d;
            mem_q   <= mem_d;
            wb_q    <= wb_d;
            state_q <= state_d;
        end
    end

    fwd_src_match #(.REG_ADDR_W(REG_ADDR_W)) u_match_src1 (
        .src(exe_q.src1), .mem_valid(mem_q.valid), .mem_wb_en(mem_q.wb_en),
        .mem_mem_read(mem_q.mem_read), .mem_dest(mem_q.dest),
        .wb_valid(wb_q.valid), .wb_wb_en(wb_q.wb_en), .wb_dest(wb_q.dest), .sel(sel1)
    );

    fwd_src_match #(.REG_ADDR_W(REG_ADDR_W)) u_match_src2 (
        .src(exe_q.src2), .mem_valid(mem_q.valid), .mem_wb_en(mem_q.wb_en),
        .mem_mem_read(mem_q.mem_read), .mem_dest(mem_q.dest),
        .wb_valid(wb_q.valid), .wb_wb_en(wb_q.wb_en), .wb_dest(wb_q.dest), .sel(sel2)
    );

    fwd_src_match #(.REG_ADDR_W(REG_ADDR_W)) u_match_store (
        .src(exe_q.src2), .mem_valid(mem_q.valid), .mem_wb_en(mem_q.wb_en),
        .mem_mem_read(mem_q.mem_read), .mem_dest(mem_q.dest),
        .wb_valid(wb_q.valid), .wb_wb_en(wb_q.wb_en), .wb_dest(wb_q.dest), .sel(sel3)
    );

    assign bus.val1_sel   = FWD_ON ? sel1 : FORW_SEL_REG;
    assign bus.val2_sel   = (FWD_ON && exe_q.uses_src2) ? sel2 : FORW_SEL_REG;
    assign bus.ST_val_sel = (FWD_ON && exe_q.is_store) ? sel3 : FORW_SEL_REG;
    assign bus.stall      = stall_c & rst;
    assign bus.bubble     = bubble_c & rst;
    assign bus.hz_state   = state_q;

endmodule
